request_queue_ord: RTL and testbench

Parametrised ordered request queue for the SmartCargo stop scheduler, successor to the fixed 16x4 stop RAM. It holds up to DEPTH stop codes in service order and supports five operations: tail append, head pop, indexed insert with back-shift, indexed delete with front-shift, and synchronous flush. It tracks occupancy explicitly, offers optional duplicate suppression and reports classified errors. It sits between the call-capture logic and the elevator controller FSM, which consumes `head`.

---
 rtl/request_queue_pkg.sv | 11 +
 rtl/request_queue_match.sv | 24 ++
 rtl/request_queue_ord.sv | 181 ++++++++++++++++++
 tb/tb_request_queue_ord.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/request_queue_pkg.sv
// rtl/request_queue_pkg.sv - shared error codes for the ordered request queue
package request_queue_pkg;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_CONFLICT  = 2'd0;
    localparam err_code_t ERR_OVERFLOW  = 2'd1;
    localparam err_code_t ERR_UNDERFLOW = 2'd2;
    localparam err_code_t ERR_BAD_INDEX = 2'd3;

endpackage

// File: rtl/request_queue_match.sv
// rtl/request_queue_match.sv - parallel compare of a code against the valid queue entries
module request_queue_match #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH*WIDTH-1:0] entries,
    input  logic [CW-1:0]          count,
    input  logic                   excl_head,
    input  logic [WIDTH-1:0]       data,
    output logic                   hit
);

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count) && !(excl_head && (i == 0)) &&
                (entries[i*WIDTH +: WIDTH] == data)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/request_queue_ord.sv
// rtl/request_queue_ord.sv - ordered stop queue with append/pop/insert/delete/flush
module request_queue_ord
    import request_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 4,
    parameter int DEDUP = 1,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int IW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic             ins,
    input  logic             del,
    input  logic [WIDTH-1:0] data,
    input  logic [IW-1:0]    idx,
    input  logic [IW-1:0]    rd_addr,
    input  logic [IW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] rd_data2,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             err,
    output err_code_t        err_code,
    output logic             dup
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;
    logic             dup_q, dup_d;
    err_code_t        code_q, code_d;

    logic [DEPTH*WIDTH-1:0] entries, shift_dn, shift_up;
    logic [2:0]             n_req;
    logic                   legal, hit, dup_hit;
    logic                   do_remove, do_insert, do_tail;
    logic [CW-1:0]          rm_pos, in_pos, tail_pos, idx_ext;

    always_comb begin
        entries = '0;
        for (int i = 0; i < DEPTH; i++) entries[i*WIDTH +: WIDTH] = mem_q[i];
    end

    // Entries beyond count are zero, so plain shifts pull zeros into the vacated slots.
    assign shift_dn = entries >> WIDTH;
    assign shift_up = entries << WIDTH;

    request_queue_match #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_match (
        .entries   (entries),
        .count     (count_q),
        .excl_head (pop),
        .data      (data),
        .hit       (hit)
    );

    assign dup_hit  = (DEDUP != 0) && hit;
    assign n_req    = 3'(push) + 3'(pop) + 3'(ins) + 3'(del);
    assign legal    = (n_req == 3'd1) || ((n_req == 3'd2) && push && pop);
    assign idx_ext  = CW'(idx);
    assign tail_pos = count_q - CW'(1);

    always_comb begin
        mem_d     = mem_q;
        count_d   = count_q;
        err_d     = 1'b0;
        dup_d     = 1'b0;
        code_d    = code_q;
        do_remove = 1'b0;
        do_insert = 1'b0;
        do_tail   = 1'b0;
        rm_pos    = '0;
        in_pos    = '0;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
            count_d = '0;
        end else if (n_req != 3'd0) begin
            if (!legal) begin
                err_d  = 1'b1;
                code_d = ERR_CONFLICT;
            end else if (push && pop) begin
                if (empty) begin
                    do_insert = 1'b1;
                    count_d   = CW'(1);
                    err_d     = 1'b1;
                    code_d    = ERR_UNDERFLOW;
                end else begin
                    do_remove = 1'b1;
                    if (dup_hit) begin
                        dup_d   = 1'b1;
                        count_d = count_q - CW'(1);
                    end else begin
                        do_tail = 1'b1;
                    end
                end
            end else if (push) begin
                if (full) begin
                    err_d  = 1'b1;
                    code_d = ERR_OVERFLOW;
                end else if (dup_hit) begin
                    dup_d = 1'b1;
                end else begin
                    do_insert = 1'b1;
                    in_pos    = count_q;
                    count_d   = count_q + CW'(1);
                end
            end else if (pop) begin
                if (empty) begin
                    err_d  = 1'b1;
                    code_d = ERR_UNDERFLOW;
                end else begin
                    do_remove = 1'b1;
                    count_d   = count_q - CW'(1);
                end
            end else if (ins) begin
                if (idx_ext > count_q) begin
                    err_d  = 1'b1;
                    code_d = ERR_BAD_INDEX;
                end else if (full) begin
                    err_d  = 1'b1;
                    code_d = ERR_OVERFLOW;
                end else if (dup_hit) begin
                    dup_d = 1'b1;
                end else begin
                    do_insert = 1'b1;
                    in_pos    = idx_ext;
                    count_d   = count_q + CW'(1);
                end
            end else begin
                if (idx_ext >= count_q) begin
                    err_d  = 1'b1;
                    code_d = ERR_BAD_INDEX;
                end else begin
                    do_remove = 1'b1;
                    rm_pos    = idx_ext;
                    count_d   = count_q - CW'(1);
                end
            end
        end
        // Tail write follows the removal so a combined push+pop lands at count-1.
        for (int i = 0; i < DEPTH; i++) begin
            if (do_remove && (CW'(i) >= rm_pos)) mem_d[i] = shift_dn[i*WIDTH +: WIDTH];
            if (do_insert && (CW'(i) > in_pos))  mem_d[i] = shift_up[i*WIDTH +: WIDTH];
            if (do_insert && (CW'(i) == in_pos)) mem_d[i] = data;
            if (do_tail && (CW'(i) == tail_pos)) mem_d[i] = data;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            dup_q   <= 1'b0;
            code_q  <= ERR_CONFLICT;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
            err_q   <= err_d;
            dup_q   <= dup_d;
            code_q  <= code_d;
        end
    end

    assign head     = mem_q[0];
    assign rd_data  = mem_q[rd_addr];
    assign rd_data2 = mem_q[rd_addr2];
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign err      = err_q;
    assign dup      = dup_q;
    assign err_code = code_q;

endmodule

// File: tb/tb_request_queue_ord.sv
// tb/tb_request_queue_ord.sv - directed and random checks of request_queue_ord against a queue model
module tb_request_queue_ord;

    localparam int DEPTH = 16;
    localparam int WIDTH = 4;
    localparam int DEDUP = 1;

    logic       clk = 1'b0;
    logic       clear_n, flush, push, pop, ins, del;
    logic [3:0] data, idx, rd_addr, rd_addr2;
    logic [3:0] head, rd_data, rd_data2;
    logic [4:0] count;
    logic       empty, full, err, dup;
    logic [1:0] err_code;

    int total = 0;
    int bad   = 0;

    int q[$];
    bit m_err, m_dup;
    int m_code = 0;

    always #5 clk = ~clk;

    request_queue_ord #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DEDUP(DEDUP)) dut (
        .clk(clk), .clear_n(clear_n), .flush(flush), .push(push), .pop(pop),
        .ins(ins), .del(del), .data(data), .idx(idx), .rd_addr(rd_addr),
        .rd_addr2(rd_addr2), .head(head), .rd_data(rd_data), .rd_data2(rd_data2),
        .count(count), .empty(empty), .full(full), .err(err), .err_code(err_code),
        .dup(dup)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bool_present(input int d);
        foreach (q[k]) if (q[k] == d) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int entry_at(input int a);
        return (a < q.size()) ? q[a] : 0;
    endfunction

    task automatic model(input bit cl, input bit f, input bit pu, input bit po,
                         input bit in_, input bit de, input int d, input int ix);
        int n;
        m_err = 1'b0;
        m_dup = 1'b0;
        n = int'(pu) + int'(po) + int'(in_) + int'(de);
        if (cl) begin
            q.delete();
            m_code = 0;
        end else if (f) begin
            q.delete();
        end else if (n == 0) begin
        end else if (!(n == 1 || (n == 2 && pu && po))) begin
            m_err = 1'b1; m_code = 0;
        end else if (pu && po) begin
            if (q.size() == 0) begin
                q.push_back(d);
                m_err = 1'b1; m_code = 2;
            end else begin
                void'(q.pop_front());
                if (DEDUP != 0 && bool_present(d)) m_dup = 1'b1;
                else q.push_back(d);
            end
        end else if (pu) begin
            if (q.size() == DEPTH) begin m_err = 1'b1; m_code = 1; end
            else if (DEDUP != 0 && bool_present(d)) m_dup = 1'b1;
            else q.push_back(d);
        end else if (po) begin
            if (q.size() == 0) begin m_err = 1'b1; m_code = 2; end
            else void'(q.pop_front());
        end else if (in_) begin
            if (ix > q.size()) begin m_err = 1'b1; m_code = 3; end
            else if (q.size() == DEPTH) begin m_err = 1'b1; m_code = 1; end
            else if (DEDUP != 0 && bool_present(d)) m_dup = 1'b1;
            else q.insert(ix, d);
        end else begin
            if (ix >= q.size()) begin m_err = 1'b1; m_code = 3; end
            else q.delete(ix);
        end
    endtask

    task automatic verify(input string tag);
        check({tag, ".count"}, 32'(count), 32'(q.size()));
        check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        check({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        check({tag, ".head"}, 32'(head), 32'(entry_at(0)));
        check({tag, ".err"}, 32'(err), 32'(m_err));
        check({tag, ".dup"}, 32'(dup), 32'(m_dup));
        check({tag, ".err_code"}, 32'(err_code), 32'(m_code));
        check({tag, ".rd_data"}, 32'(rd_data), 32'(entry_at(int'(rd_addr))));
        check({tag, ".rd_data2"}, 32'(rd_data2), 32'(entry_at(int'(rd_addr2))));
    endtask

    task automatic step(input string tag, input bit cl, input bit f, input bit pu, input bit po,
                        input bit in_, input bit de, input int d, input int ix);
        clear_n  = ~cl;
        flush    = f;
        push     = pu;
        pop      = po;
        ins      = in_;
        del      = de;
        data     = 4'(d);
        idx      = 4'(ix);
        rd_addr  = 4'($urandom_range(0, 15));
        rd_addr2 = 4'($urandom_range(0, 15));
        @(posedge clk);
        #1;
        model(cl, f, pu, po, in_, de, d, ix);
        verify(tag);
    endtask

    task automatic sweep(input string tag);
        {flush, push, pop, ins, del} = 5'b0;
        clear_n = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr  = 4'(a);
            rd_addr2 = 4'(DEPTH - 1 - a);
            #1;
            check({tag, ".sweep"}, 32'(rd_data), 32'(entry_at(a)));
            check({tag, ".sweep2"}, 32'(rd_data2), 32'(entry_at(DEPTH - 1 - a)));
        end
    endtask

    initial begin
        logic [3:0] bits;
        int r, sel, d, ix;
        bit cl, f;

        {flush, push, pop, ins, del} = 5'b0;
        clear_n = 1'b0; data = '0; idx = '0; rd_addr = '0; rd_addr2 = '0;
        step("reset", 1, 0, 0, 0, 0, 0, 0, 0);
        check("reset.empty_const", 32'(empty), 32'd1);
        check("reset.count_const", 32'(count), 32'd0);
        step("idle", 0, 0, 0, 0, 0, 0, 0, 0);

        step("push3", 0, 0, 1, 0, 0, 0, 3, 0);
        step("push7", 0, 0, 1, 0, 0, 0, 7, 0);
        step("push5", 0, 0, 1, 0, 0, 0, 5, 0);
        check("plan1.head", 32'(head), 32'd3);
        step("pop", 0, 0, 0, 1, 0, 0, 0, 0);
        sweep("plan1");

        step("flush", 0, 1, 0, 0, 0, 0, 0, 0);
        step("p3", 0, 0, 1, 0, 0, 0, 3, 0);
        step("p7", 0, 0, 1, 0, 0, 0, 7, 0);
        step("p5", 0, 0, 1, 0, 0, 0, 5, 0);
        step("ins1", 0, 0, 0, 0, 1, 0, 9, 1);
        step("del2", 0, 0, 0, 0, 0, 1, 0, 2);
        sweep("plan2");

        step("flush", 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= DEPTH; i++) step("fill", 0, 0, 1, 0, 0, 0, i % 16, 0);
        step("ovf", 0, 0, 1, 0, 0, 0, 2, 0);
        step("pushpop_full", 0, 0, 1, 1, 0, 0, 0, 0);
        step("ins_full", 0, 0, 0, 0, 1, 0, 14, 3);
        sweep("plan3");

        step("flush", 0, 1, 0, 0, 0, 0, 0, 0);
        step("unf", 0, 0, 0, 1, 0, 0, 0, 0);
        step("pushpop_empty", 0, 0, 1, 1, 0, 0, 4, 0);
        step("idle_after", 0, 0, 0, 0, 0, 0, 0, 0);

        step("flush", 0, 1, 0, 0, 0, 0, 0, 0);
        step("d3", 0, 0, 1, 0, 0, 0, 3, 0);
        step("d7", 0, 0, 1, 0, 0, 0, 7, 0);
        step("dup7", 0, 0, 1, 0, 0, 0, 7, 0);
        step("pushpop3", 0, 0, 1, 1, 0, 0, 3, 0);
        step("ins_bad", 0, 0, 0, 0, 1, 0, 1, 3);
        step("del_bad", 0, 0, 0, 0, 0, 1, 0, 2);
        step("ins_tail", 0, 0, 0, 0, 1, 0, 11, 2);
        step("conflict", 0, 0, 0, 0, 1, 1, 6, 0);
        step("flush_push", 0, 1, 1, 0, 0, 0, 8, 0);
        step("p8", 0, 0, 1, 0, 0, 0, 8, 0);
        step("clear_pop", 1, 0, 0, 1, 0, 0, 0, 0);
        sweep("plan6");

        for (int n = 0; n < 600; n++) begin
            r   = $urandom_range(0, 99);
            cl  = (r == 0);
            f   = (r == 1 || r == 2);
            sel = $urandom_range(0, 9);
            d   = $urandom_range(0, 15);
            ix  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15)
                                               : $urandom_range(0, (q.size() < 15) ? q.size() + 1 : 15);
            bits = 4'($urandom_range(0, 15));
            case (sel)
                0, 1, 2: step("rnd.push", cl, f, 1, 0, 0, 0, d, ix);
                3, 4:    step("rnd.pop", cl, f, 0, 1, 0, 0, d, ix);
                5:       step("rnd.ins", cl, f, 0, 0, 1, 0, d, ix);
                6:       step("rnd.del", cl, f, 0, 0, 0, 1, d, ix);
                7:       step("rnd.pushpop", cl, f, 1, 1, 0, 0, d, ix);
                8:       step("rnd.mix", cl, f, bits[3], bits[2], bits[1], bits[0], d, ix);
                default: step("rnd.idle", cl, f, 0, 0, 0, 0, d, ix);
            endcase
        end
        sweep("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
